wm_cycle_timer: RTL and testbench
=================================

# wm_cycle_timer

- Stage-duration timer on the plant side of the washing-machine controller interface.
- Consumes the controller's stage-enable outputs (soak_op, wash_op, rinse_op, spin_op) plus lid and mode.
- Produces the soak_done/wash_done/rinse_done/spin_done inputs the controller waits on, closing the stage-sequencing loop.
- Pairs with washing_machine_ctrl at system level and replaces hand-driven done stimulus in benches.

## Interface
- TICK_DIV, 1000: clock cycles per timer tick; legal range ≥1.
- CNT_W, 16: width of the tick counter.
- SOAK_T, 10: soak duration in ticks; 0 treated as 1.
- WASH_T, 20: wash duration in ticks; 0 treated as 1.
- RINSE_T, 15: rinse duration in ticks; 0 treated as 1.
- SPIN_T, 12: spin duration in ticks; 0 treated as 1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- soak_op, wash_op, rinse_op, spin_op  in  1 each  stage enables from controller, level.
- lid  in  1  1 = lid open.
- mode  in  2  00 normal, 01 quick, 10 heavy, 11 normal.
- soak_done, wash_done, rinse_done, spin_done  out  1 each  single-cycle completion pulses.
- busy  out  1  high in RUN or PAUSE.
- remaining  out  CNT_W  ticks left in current stage; 0 when not busy.
- err  out  1  sticky: more than one stage enable seen high in the same cycle.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset: state IDLE; all outputs 0 (every *_done, busy, remaining, err); counter and prescaler 0.
- **IDLE**
  - Exactly one op high: latch the stage and mode, load counter with the scaled duration, clear prescaler, go RUN.
  - More than one op high: set err, stay IDLE.
  - Zero ops high: stay IDLE.
- **Scaling**, applied at load from the latched mode; mode changes mid-stage are ignored:
  - normal: D.
  - quick: D>>1, minimum 1.
  - heavy: D<<1, saturating at 2^CNT_W−1.
- **RUN**
  - Prescaler counts 0..TICK_DIV−1; a tick occurs when it equals TICK_DIV−1, and it wraps to 0 on the same edge.
  - Counter decrements on each tick.
  - On a tick with counter==1: counter→0, go DONE, and the latched stage's *_done goes high for exactly one cycle.
- **Abort**: the latched op deasserts in RUN or PAUSE → IDLE, no done pulse, remaining→0. If another op is already high, it starts from IDLE on the following edge.
- **PAUSE**
  - Entered from RUN only when the latched stage is spin and lid=1; prescaler and counter are frozen.
  - lid=0 returns to RUN, resuming the prescaler from its frozen value.
  - lid is ignored for soak, wash and rinse.
- **DONE**: wait until the latched op deasserts, then IDLE. This prevents a retrigger while the controller is still sampling done.
- err clears only on reset.

## Timing
- op first sampled high at edge E0 → RUN from E0; remaining = scaled D after E0.
- Done pulse visible in the cycle following edge E0 + D·TICK_DIV (scaled D), i.e. registered output.
- busy asserts one cycle after op is sampled high.
- Abort and PAUSE entry take effect on the edge that samples the condition.
- Simultaneous cases:
  - Tick and lid rise on the same edge in spin: the tick is applied, then PAUSE.
  - Tick reaching 0 and op deassert on the same edge: abort wins, no done pulse.
- Reset mid-stage: immediate return to IDLE, outputs 0, no done pulse.

## Structure
- Shared package wm_pkg:
  - stage enum (NONE, SOAK, WASH, RINSE, SPIN);
  - mode encodings;
  - timer state enum;
  - the scaling function.
- Sub-module wm_tick_prescaler (TICK_DIV counter, enable/clear inputs, tick output), reusable by the controller for lid debounce.

## Test plan
- TICK_DIV=4, SOAK_T=3, mode=00, soak_op held high → soak_done single pulse 12 cycles after start, remaining steps 3→2→1→0, busy low afterwards.
- WASH_T=20, mode=01 → wash_done after 10 ticks. Same stage with mode=10 → 40 ticks. SPIN_T=0 with mode=01 → spin_done after 1 tick.
- Spin running, remaining=5: lid=1 for 30 cycles, then lid=0 → remaining frozen at 5 during PAUSE; spin_done delayed by exactly 30 cycles.
- rinse_op dropped at remaining=4 → no rinse_done, IDLE next cycle. wash_op raised the same cycle → wash run starts one cycle later.
- soak_op and wash_op high together from IDLE → err=1 and sticky, busy stays 0. rst_n low → err=0.
- rst_n pulsed low mid-wash → all outputs 0 asynchronously. With wash_op still high after release → a fresh full-duration wash.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared types and helpers for the washing-machine stage timer.
// Stage/mode encodings and the duration scaling rule live here so the controller can reuse them.
package wm_pkg;

    typedef enum logic [2:0] {
        STG_NONE  = 3'd0,
        STG_SOAK  = 3'd1,
        STG_WASH  = 3'd2,
        STG_RINSE = 3'd3,
        STG_SPIN  = 3'd4
    } stage_e;

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'b00,
        MODE_QUICK      = 2'b01,
        MODE_HEAVY      = 2'b10,
        MODE_NORMAL_ALT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } tmr_state_e;

    localparam int unsigned NUM_STAGES = 4;

    // Zero durations behave as one tick; heavy doubling clamps to the counter maximum.
    function automatic logic [31:0] scale_dur(input logic [31:0] dur, input mode_e mode,
                                              input logic [31:0] max_val);
        logic [32:0] base;
        logic [32:0] res;
        base = (dur == 32'd0) ? 33'd1 : {1'b0, dur};
        case (mode)
            MODE_QUICK: begin
                res = base >> 1;
                if (res == 33'd0) res = 33'd1;
            end
            MODE_HEAVY: res = base << 1;
            default:    res = base;
        endcase
        if (res > {1'b0, max_val}) res = {1'b0, max_val};
        return res[31:0];
    endfunction

    // Done-pulse bit position: bit 0 soak .. bit 3 spin.
    function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_e s);
        logic [NUM_STAGES-1:0] oh;
        oh = '0;
        case (s)
            STG_SOAK:  oh[0] = 1'b1;
            STG_WASH:  oh[1] = 1'b1;
            STG_RINSE: oh[2] = 1'b1;
            STG_SPIN:  oh[3] = 1'b1;
            default:   oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/wm_cycle_timer_if.sv
// Controller <-> stage timer signal bundle.
// master = controller side (drives enables), slave = timer side (drives done pulses).
interface wm_cycle_timer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             soak_op;
    logic             wash_op;
    logic             rinse_op;
    logic             spin_op;
    logic             lid;
    logic [1:0]       mode;
    logic             soak_done;
    logic             wash_done;
    logic             rinse_done;
    logic             spin_done;
    logic             busy;
    logic [CNT_W-1:0] remaining;
    logic             err;

    modport master (
        output soak_op, wash_op, rinse_op, spin_op, lid, mode,
        input  soak_done, wash_done, rinse_done, spin_done, busy, remaining, err
    );

    modport slave (
        input  soak_op, wash_op, rinse_op, spin_op, lid, mode,
        output soak_done, wash_done, rinse_done, spin_done, busy, remaining, err
    );
endinterface

// File: rtl/wm_tick_prescaler.sv
// Free-running divide-by-TICK_DIV counter with enable and clear; tick is high on the last count.
// Freezes its count while en is low, so a paused stage resumes mid-tick.
module wm_tick_prescaler #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)       cnt_d = '0;
        else if (tick) cnt_d = '0;
        else if (en)   cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/wm_cycle_timer.sv
// Plant-side stage timer: turns a held stage enable into a timed single-cycle done pulse.
// Spin pauses while the lid is open; dropping the enable aborts without a pulse.
module wm_cycle_timer
    import wm_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SOAK_T   = 10,
    parameter int unsigned WASH_T   = 20,
    parameter int unsigned RINSE_T  = 15,
    parameter int unsigned SPIN_T   = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    wm_cycle_timer_if.slave bus
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    tmr_state_e            state_q, state_d;
    stage_e                stage_q, stage_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] done_q, done_d;
    logic                  err_q, err_d;

    logic [NUM_STAGES-1:0] ops;
    logic                  ops_one, ops_multi;
    logic                  op_held;
    logic                  tick, ps_en, ps_clr;
    logic                  busy;
    stage_e                req_stage;
    logic [31:0]           req_base;

    assign ops       = {bus.spin_op, bus.rinse_op, bus.wash_op, bus.soak_op};
    assign ops_one   = (ops != '0) && ((ops & (ops - 1'b1)) == '0);
    assign ops_multi = (ops != '0) && !ops_one;

    // Only meaningful when exactly one enable is high.
    always_comb begin
        req_stage = STG_NONE;
        req_base  = 32'd0;
        if (bus.soak_op) begin
            req_stage = STG_SOAK;
            req_base  = 32'(SOAK_T);
        end else if (bus.wash_op) begin
            req_stage = STG_WASH;
            req_base  = 32'(WASH_T);
        end else if (bus.rinse_op) begin
            req_stage = STG_RINSE;
            req_base  = 32'(RINSE_T);
        end else if (bus.spin_op) begin
            req_stage = STG_SPIN;
            req_base  = 32'(SPIN_T);
        end
    end

    always_comb begin
        case (stage_q)
            STG_SOAK:  op_held = bus.soak_op;
            STG_WASH:  op_held = bus.wash_op;
            STG_RINSE: op_held = bus.rinse_op;
            STG_SPIN:  op_held = bus.spin_op;
            default:   op_held = 1'b0;
        endcase
    end

    assign ps_en  = (state_q == ST_RUN);
    assign ps_clr = (state_q == ST_IDLE) && ops_one;

    wm_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ps_en),
        .clr  (ps_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ops_multi) begin
                    err_d = 1'b1;
                end else if (ops_one) begin
                    stage_d = req_stage;
                    cnt_d   = CNT_W'(scale_dur(req_base, mode_e'(bus.mode), CNT_MAX));
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort beats a same-edge final tick.
                if (!op_held) begin
                    state_d = ST_IDLE;
                    stage_d = STG_NONE;
                    cnt_d   = '0;
                end else begin
                    if (tick) cnt_d = cnt_q - 1'b1;
                    if (tick && (cnt_q == CNT_W'(1))) begin
                        state_d = ST_DONE;
                        done_d  = stage_onehot(stage_q);
                    end else if ((stage_q == STG_SPIN) && bus.lid) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (!op_held) begin
                    state_d = ST_IDLE;
                    stage_d = STG_NONE;
                    cnt_d   = '0;
                end else if (!bus.lid) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // Hold here until the controller releases the enable, so it cannot retrigger.
                if (!op_held) begin
                    state_d = ST_IDLE;
                    stage_d = STG_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stage_q <= STG_NONE;
            cnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy           = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign bus.busy       = busy;
    assign bus.remaining  = busy ? cnt_q : '0;
    assign bus.soak_done  = done_q[0];
    assign bus.wash_done  = done_q[1];
    assign bus.rinse_done = done_q[2];
    assign bus.spin_done  = done_q[3];
    assign bus.err        = err_q;
endmodule

// File: tb/tb_wm_cycle_timer.sv
// Randomized scoreboard bench for wm_cycle_timer; a second instance covers zero/saturating durations.
`timescale 1ns/1ps
module tb_wm_cycle_timer;
    localparam int TD = 4;
    localparam int BASE_M [4] = '{3, 20, 15, 12};
    localparam int BASE_Z [4] = '{0, 40000, 1, 0};

    typedef struct {
        int st;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wm_cycle_timer_if #(.CNT_W(16)) bus_m ();
    wm_cycle_timer_if #(.CNT_W(16)) bus_z ();

    logic [3:0] ops_m = '0, ops_z = '0;
    logic       lid_m = 1'b0, lid_z = 1'b0;
    logic [1:0] mode_m = '0, mode_z = '0;

    assign bus_m.soak_op  = ops_m[0];
    assign bus_m.wash_op  = ops_m[1];
    assign bus_m.rinse_op = ops_m[2];
    assign bus_m.spin_op  = ops_m[3];
    assign bus_m.lid      = lid_m;
    assign bus_m.mode     = mode_m;
    assign bus_z.soak_op  = ops_z[0];
    assign bus_z.wash_op  = ops_z[1];
    assign bus_z.rinse_op = ops_z[2];
    assign bus_z.spin_op  = ops_z[3];
    assign bus_z.lid      = lid_z;
    assign bus_z.mode     = mode_z;

    wm_cycle_timer #(
        .TICK_DIV(TD), .CNT_W(16), .SOAK_T(3), .WASH_T(20), .RINSE_T(15), .SPIN_T(12)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_m)
    );

    wm_cycle_timer #(
        .TICK_DIV(TD), .CNT_W(16), .SOAK_T(0), .WASH_T(40000), .RINSE_T(1), .SPIN_T(0)
    ) u_dut_z (
        .clk(clk), .rst_n(rst_n), .bus(bus_z)
    );

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference duration rule: 0 counts as 1, quick halves (min 1), heavy doubles (clamped).
    function automatic int scaled(input int base_d, input int md);
        int d;
        d = (base_d == 0) ? 1 : base_d;
        if (md == 1)      d = (d / 2 == 0) ? 1 : d / 2;
        else if (md == 2) d = (d * 2 > 65535) ? 65535 : d * 2;
        return d;
    endfunction

    function automatic logic [3:0] done_m();
        return {bus_m.spin_done, bus_m.rinse_done, bus_m.wash_done, bus_m.soak_done};
    endfunction

    function automatic logic [3:0] done_z();
        return {bus_z.spin_done, bus_z.rinse_done, bus_z.wash_done, bus_z.soak_done};
    endfunction

    task automatic push(input int st, input int c);
        exp_t e;
        e.st  = st;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [3:0] dn;
        exp_t       e;
        dn = done_m();
        if (dn != 4'd0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", dn, 0);
            end else begin
                e = exp_q.pop_front();
                chk("done_stage", dn, 4'd1 << e.st);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // One stage on the main instance: op rises, optional lid window at k for L cycles, or abort at k.
    task automatic run_stage(input int st, input int md, input bit abort_it, input int k, input int L);
        int d, c0, t_done;
        d = scaled(BASE_M[st], md);
        @(negedge clk);
        ops_m  = 4'd1 << st;
        mode_m = 2'(md);
        c0     = cyc + 1;
        t_done = c0 + d * TD + ((st == 3) ? L : 0);
        if (!abort_it) push(st, t_done);
        @(negedge clk);
        chk("busy_start", bus_m.busy, 1);
        chk("rem_start", bus_m.remaining, d);
        mode_m = 2'($urandom_range(3, 0));
        wait_until(c0 + k);
        if (abort_it) begin
            ops_m = '0;
            @(negedge clk);
            chk("abort_busy", bus_m.busy, 0);
            chk("abort_rem", bus_m.remaining, 0);
        end else begin
            chk("rem_mid", bus_m.remaining, d - k / TD);
            lid_m = 1'b1;
            repeat (L) @(negedge clk);
            if (st == 3) begin
                chk("pause_rem", bus_m.remaining, d - (k + 1) / TD);
                chk("pause_busy", bus_m.busy, 1);
            end
            lid_m = 1'b0;
            wait_until(t_done);
            chk("done_busy", bus_m.busy, 0);
            chk("done_rem", bus_m.remaining, 0);
            ops_m = '0;
            @(negedge clk);
            chk("idle_busy", bus_m.busy, 0);
        end
    endtask

    task automatic run_random();
        int st, md, d, k, L;
        bit ab;
        st = int'($urandom_range(3, 0));
        md = int'($urandom_range(3, 0));
        d  = scaled(BASE_M[st], md);
        ab = ($urandom_range(3, 0) == 0);
        if (ab) k = ($urandom_range(3, 0) == 0) ? d * TD - 1 : int'($urandom_range(d * TD - 1, 0));
        else    k = int'($urandom_range(d * TD - 2, 0));
        L = int'($urandom_range(40, 1));
        run_stage(st, md, ab, k, L);
    endtask

    // Zero-duration / saturation instance, checked directly.
    task automatic z_run(input int st, input int md, input bit complete);
        int d, c0;
        d = scaled(BASE_Z[st], md);
        @(negedge clk);
        ops_z  = 4'd1 << st;
        mode_z = 2'(md);
        c0     = cyc + 1;
        @(negedge clk);
        chk("z_rem_start", bus_z.remaining, d);
        if (complete) begin
            wait_until(c0 + d * TD - 1);
            chk("z_done_early", done_z(), 0);
            @(negedge clk);
            chk("z_done", done_z(), 4'd1 << st);
        end
        ops_z = '0;
        @(negedge clk);
        chk("z_idle_busy", bus_z.busy, 0);
        chk("z_idle_done", done_z(), 0);
    endtask

    initial begin
        int c0, c1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", bus_m.busy, 0);
        chk("rst_rem", bus_m.remaining, 0);
        chk("rst_err", bus_m.err, 0);
        chk("rst_done", done_m(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed: soak normal, wash quick/heavy, spin paused 30 cycles at remaining 5.
        run_stage(0, 0, 1'b0, 4, 1);
        run_stage(1, 1, 1'b0, 5, 3);
        run_stage(1, 2, 1'b0, 100, 3);
        run_stage(3, 0, 1'b0, 28, 30);

        // Rinse aborted at remaining 4 while wash is raised in the same cycle.
        @(negedge clk);
        ops_m  = 4'b0100;
        mode_m = 2'd0;
        c0     = cyc + 1;
        wait_until(c0 + 44);
        chk("rinse_rem4", bus_m.remaining, 4);
        ops_m = 4'b0010;
        @(negedge clk);
        chk("swap_busy", bus_m.busy, 0);
        chk("swap_rem", bus_m.remaining, 0);
        c1 = cyc + 1;
        push(1, c1 + 20 * TD);
        @(negedge clk);
        chk("swap_wash_busy", bus_m.busy, 1);
        chk("swap_wash_rem", bus_m.remaining, 20);
        wait_until(c1 + 20 * TD);
        ops_m = '0;
        @(negedge clk);

        for (int i = 0; i < 30; i++) run_random();

        // Two enables together: err sticks, no run starts, reset clears it.
        @(negedge clk);
        ops_m = 4'b0011;
        @(negedge clk);
        chk("err_set", bus_m.err, 1);
        chk("err_busy", bus_m.busy, 0);
        ops_m = '0;
        run_stage(2, 1, 1'b0, 2, 1);
        chk("err_sticky", bus_m.err, 1);
        rst_n = 1'b0;
        #1;
        chk("err_reset", bus_m.err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-wash, then the held enable starts a fresh full wash.
        @(negedge clk);
        ops_m  = 4'b0010;
        mode_m = 2'd0;
        c0     = cyc + 1;
        wait_until(c0 + 30);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", bus_m.busy, 0);
        chk("rst_mid_rem", bus_m.remaining, 0);
        chk("rst_mid_done", done_m(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        c0    = cyc + 1;
        push(1, c0 + 20 * TD);
        @(negedge clk);
        chk("fresh_wash_rem", bus_m.remaining, 20);
        wait_until(c0 + 20 * TD);
        ops_m = '0;
        @(negedge clk);

        z_run(3, 1, 1'b1);
        z_run(3, 0, 1'b1);
        z_run(0, 2, 1'b1);
        z_run(2, 1, 1'b1);
        z_run(1, 2, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
